// File: rtl/mmio_uart_tx_pkg.sv
// Shared OTTER MMIO definitions: IOBUS address map, UART FSM states, status bit positions.
package otter_mmio_pkg;

   localparam logic [31:0] SWITCHES_AD  = 32'h1100_0000;
   localparam logic [31:0] LEDS_AD      = 32'h1100_0020;
   localparam logic [31:0] SSEG_AD      = 32'h1100_0040;
   localparam logic [31:0] UART_DATA_AD = 32'h1100_0060;
   localparam logic [31:0] UART_STAT_AD = 32'h1100_0064;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   localparam int unsigned STAT_TX_ACTIVE = 0;
   localparam int unsigned STAT_FULL      = 1;
   localparam int unsigned STAT_EMPTY     = 2;
   localparam int unsigned STAT_OVF       = 3;
   localparam int unsigned STAT_CNT_LSB   = 8;

   // Bit period in clocks, rounded to nearest.
   function automatic int unsigned bit_div(input int unsigned clk_hz, input int unsigned baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// OTTER IOBUS slice seen by the UART: address, write data/strobe, and the read-back word.
interface mmio_uart_tx_if;
   logic [31:0] IOBUS_ADDR;
   logic [31:0] IOBUS_OUT;
   logic        IOBUS_WR;
   logic [31:0] RD_DATA;

   modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input RD_DATA);
   modport slave  (input IOBUS_ADDR, input IOBUS_OUT, input IOBUS_WR, output RD_DATA);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO; a push while full is dropped unless a pop shares the edge.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// IOBUS-mapped 8N1 UART transmitter: byte FIFO fed by CPU stores, status word on the read path.
module mmio_uart_tx
   import otter_mmio_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] DATA_AD    = UART_DATA_AD,
   parameter logic [31:0] STAT_AD    = UART_STAT_AD
) (
   input  logic          CLK,
   input  logic          RST,
   mmio_uart_tx_if.slave iobus,
   output logic          TX,
   output logic          BUSY
);
   localparam int unsigned BIT_DIV = bit_div(CLK_HZ, BAUD);
   localparam int unsigned BAUD_W  = $clog2(BIT_DIV);
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_DIV - 1);

   uart_state_t       state_q, state_d;
   logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              ovf_q, ovf_d;

   logic              data_wr, clr_ovf, pop;
   logic [7:0]        fifo_rdata;
   logic              fifo_full, fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              unused_bits;

   assign data_wr     = iobus.IOBUS_WR && (iobus.IOBUS_ADDR == DATA_AD);
   assign clr_ovf     = iobus.IOBUS_WR && (iobus.IOBUS_ADDR == STAT_AD) && iobus.IOBUS_OUT[3];
   assign unused_bits = ^iobus.IOBUS_OUT[31:8];

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (data_wr),
      .pop   (pop),
      .wdata (iobus.IOBUS_OUT[7:0]),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // A set on the same edge as a clear wins.
   assign ovf_d = (data_wr & fifo_full & ~pop) | (ovf_q & ~clr_ovf);

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop        = 1'b1;
               shift_d    = fifo_rdata;
               tx_d       = 1'b0;
               baud_cnt_d = '0;
               state_d    = START;
            end
         end
         START: begin
            baud_cnt_d = baud_cnt_q + 1'b1;
            if (baud_cnt_q == BAUD_LAST) begin
               baud_cnt_d = '0;
               tx_d       = shift_q[0];
               bit_idx_d  = '0;
               state_d    = DATA;
            end
         end
         DATA: begin
            baud_cnt_d = baud_cnt_q + 1'b1;
            if (baud_cnt_q == BAUD_LAST) begin
               baud_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  // Shift register keeps the bit being sent in [0].
                  bit_idx_d = bit_idx_q + 1'b1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
               end
            end
         end
         STOP: begin
            baud_cnt_d = baud_cnt_q + 1'b1;
            if (baud_cnt_q == BAUD_LAST) begin
               baud_cnt_d = '0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_rdata;
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         ovf_q      <= ovf_d;
      end
   end

   always_comb begin
      iobus.RD_DATA = '0;
      if (iobus.IOBUS_ADDR == STAT_AD) begin
         iobus.RD_DATA[STAT_TX_ACTIVE]      = (state_q != IDLE);
         iobus.RD_DATA[STAT_FULL]           = fifo_full;
         iobus.RD_DATA[STAT_EMPTY]          = fifo_empty;
         iobus.RD_DATA[STAT_OVF]            = ovf_q;
         iobus.RD_DATA[STAT_CNT_LSB +: 8]   = 8'(fifo_count);
      end
   end

   assign TX   = tx_q;
   assign BUSY = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised bench for mmio_uart_tx against a frame-position model of the 8N1 line and FIFO.
module tb_mmio_uart_tx;
   import otter_mmio_pkg::*;

   localparam int unsigned CLK_HZ  = 1_000_000;
   localparam int unsigned BAUD    = 250_000;
   localparam int unsigned BIT_DIV = 4;
   localparam int unsigned DEPTH   = 8;
   localparam int unsigned FRAME   = 10 * BIT_DIV;
   localparam logic [31:0] D_AD    = 32'h1100_0060;
   localparam logic [31:0] S_AD    = 32'h1100_0064;

   logic clk = 1'b0;
   logic rst;
   logic tx, busy;
   bit   chk_en = 1'b0;
   int   total = 0;
   int   bad = 0;

   mmio_uart_tx_if bus();

   mmio_uart_tx #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH),
      .DATA_AD    (D_AD),
      .STAT_AD    (S_AD)
   ) dut (
      .CLK   (clk),
      .RST   (rst),
      .iobus (bus),
      .TX    (tx),
      .BUSY  (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: queued bytes plus the position inside the frame currently on the line.
   logic [7:0]  mq[$];
   logic [7:0]  m_cur;
   bit          m_active;
   bit          m_ovf;
   int unsigned m_pos;
   bit          m_pop;

   function automatic logic m_tx();
      int unsigned k;
      if (!m_active) return 1'b1;
      k = m_pos / BIT_DIV;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return m_cur[k-1];
   endfunction

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s       = '0;
      s[0]    = m_active;
      s[1]    = (mq.size() == DEPTH);
      s[2]    = (mq.size() == 0);
      s[3]    = m_ovf;
      s[15:8] = 8'(mq.size());
      return s;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_active = 1'b0;
         m_ovf    = 1'b0;
         m_pos    = 0;
         m_cur    = '0;
      end else begin
         m_pop = (mq.size() > 0) && (!m_active || m_pos == FRAME - 1);
         if (m_pop) begin
            m_cur    = mq.pop_front();
            m_active = 1'b1;
            m_pos    = 0;
         end else if (m_active) begin
            if (m_pos == FRAME - 1) m_active = 1'b0;
            else m_pos++;
         end
         if (bus.IOBUS_WR && bus.IOBUS_ADDR == D_AD) begin
            if (mq.size() < DEPTH) mq.push_back(bus.IOBUS_OUT[7:0]);
            else m_ovf = 1'b1;
         end else if (bus.IOBUS_WR && bus.IOBUS_ADDR == S_AD && bus.IOBUS_OUT[3]) begin
            m_ovf = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && rst === 1'b0) begin
         check("tx", tx, m_tx());
         check("busy", busy, m_active || mq.size() > 0);
         check("rd", bus.RD_DATA, (bus.IOBUS_ADDR == S_AD) ? m_status() : 32'h0);
      end
   end

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      bus.IOBUS_ADDR = addr;
      bus.IOBUS_OUT  = data;
      bus.IOBUS_WR   = 1'b1;
      @(posedge clk); #1;
      bus.IOBUS_WR   = 1'b0;
      bus.IOBUS_OUT  = '0;
   endtask

   task automatic rd_expect(input string name, input logic [31:0] addr, input logic [31:0] exp);
      bus.IOBUS_ADDR = addr;
      @(negedge clk);
      check(name, bus.RD_DATA, exp);
      @(posedge clk); #1;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (busy && n < bound) begin
         @(posedge clk); #1;
         n++;
      end
      check("idle_timeout", 32'(n < bound), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      logic [9:0] fr;
      int         n;
      int unsigned r;
      rst = 1'b1;
      bus.IOBUS_WR   = 1'b0;
      bus.IOBUS_ADDR = '0;
      bus.IOBUS_OUT  = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      check("reset_tx", tx, 1'b1);
      check("reset_busy", busy, 1'b0);
      rd_expect("reset_stat", S_AD, 32'h0000_0004);

      // Single frame, upper data bits ignored.
      wr(D_AD, 32'hFFFF_FF55);
      fr = {1'b1, 8'h55, 1'b0};
      @(posedge clk);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check("frame55_tx", tx, fr[i/4]);
         check("frame55_busy", busy, 1'b1);
      end
      @(negedge clk);
      check("frame55_end_tx", tx, 1'b1);
      check("frame55_end_busy", busy, 1'b0);
      @(posedge clk); #1;

      // Two bytes back-to-back.
      wr(D_AD, 32'h0000_00A1);
      wr(D_AD, 32'h0000_00B2);
      rd_expect("two_cnt", S_AD, 32'h0000_0101);
      wait_idle(200);
      rd_expect("two_idle", S_AD, 32'h0000_0004);

      // Overflow with 10 writes, then clear.
      for (int i = 0; i < 10; i++) wr(D_AD, $urandom);
      rd_expect("ovf_stat", S_AD, 32'h0000_080B);
      wr(S_AD, 32'h0000_0008);
      rd_expect("ovf_clr", S_AD, 32'h0000_0803);
      wait_idle(1000);

      rd_expect("idle_stat", S_AD, 32'h0000_0004);
      rd_expect("rd_data_ad", D_AD, 32'h0);
      rd_expect("rd_other", 32'h1100_0000, 32'h0);

      // Reset in DATA bit 3 with three bytes queued.
      for (int i = 0; i < 4; i++) wr(D_AD, $urandom);
      repeat (15) @(posedge clk);
      #1;
      check("pre_rst_pos", m_pos, 17);
      rst = 1'b1;
      #1;
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      rd_expect("rst_stat", S_AD, 32'h0000_0004);
      repeat (60) @(posedge clk);
      #1 check("post_rst_tx", tx, 1'b1);

      // Push on the same edge STOP pops a full FIFO.
      for (int i = 0; i < 9; i++) wr(D_AD, $urandom);
      n = 0;
      while (!(m_active && m_pos == FRAME - 1 && mq.size() == DEPTH) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("pushpop_timeout", 32'(n < 100), 32'd1);
      wr(D_AD, 32'h0000_005A);
      rd_expect("pushpop_stat", S_AD, 32'h0000_0803);
      wait_idle(1000);

      // Random traffic.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 9);
         if (r < 5) wr(D_AD, $urandom);
         else if (r == 5) wr(S_AD, $urandom);
         else if (r == 6) wr(($urandom_range(0, 1) == 0) ? LEDS_AD : SSEG_AD, $urandom);
         else begin
            bus.IOBUS_ADDR = ($urandom_range(0, 2) == 0) ? D_AD : S_AD;
            repeat ($urandom_range(0, 40)) @(posedge clk);
            #1;
         end
      end
      bus.IOBUS_ADDR = S_AD;
      wait_idle(2000);
      rd_expect("final_stat", S_AD, {28'h0, m_ovf, 3'b100});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
